// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for a 5-stage pipeline: memory freezes, load-use bubbles, EX redirects
// (a redirect seen during a freeze is held and replayed), plus saturating perf counters.
module pipeline_hazard_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             imem_stall,
    input  logic             dmem_stall,
    input  logic             load_use,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_target,
    input  logic             counter_clr,
    output logic             load_pc,
    output logic             load_ifid,
    output logic             load_idex,
    output logic             load_exmem,
    output logic             load_memwb,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             pc_redirect,
    output logic [31:0]      pc_redirect_target,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic {
        RUN     = 1'b0,
        PENDING = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pend_target_q, pend_target_d;
    logic [2:0]  cnt_inc;
    logic        stall;

    assign stall = imem_stall | dmem_stall;

    always_comb begin
        state_d            = state_q;
        pend_target_d      = pend_target_q;
        cnt_inc            = 3'b000;
        load_pc            = 1'b0;
        load_ifid          = 1'b0;
        load_idex          = 1'b0;
        load_exmem         = 1'b0;
        load_memwb         = 1'b0;
        flush_ifid         = 1'b0;
        flush_idex         = 1'b0;
        pc_redirect        = 1'b0;
        pc_redirect_target = 32'h0;

        if (rst) begin
            if (stall) begin
                cnt_inc[0] = 1'b1;
                // Only the first redirect of a freeze is captured; later ones are younger.
                if (state_q == RUN && redirect_valid) begin
                    pend_target_d = redirect_target;
                    state_d       = PENDING;
                end
            end else if (state_q == PENDING || redirect_valid) begin
                pc_redirect        = 1'b1;
                pc_redirect_target = (state_q == PENDING) ? pend_target_q : redirect_target;
                load_pc            = 1'b1;
                load_ifid          = 1'b1;
                load_idex          = 1'b1;
                load_exmem         = 1'b1;
                load_memwb         = 1'b1;
                flush_ifid         = 1'b1;
                flush_idex         = 1'b1;
                state_d            = RUN;
                cnt_inc[2]         = 1'b1;
            end else if (load_use) begin
                load_idex  = 1'b1;
                flush_idex = 1'b1;
                load_exmem = 1'b1;
                load_memwb = 1'b1;
                cnt_inc[1] = 1'b1;
            end else begin
                load_pc    = 1'b1;
                load_ifid  = 1'b1;
                load_idex  = 1'b1;
                load_exmem = 1'b1;
                load_memwb = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= RUN;
            pend_target_q <= 32'h0;
        end else begin
            state_q       <= state_d;
            pend_target_q <= pend_target_d;
        end
    end

    // Counter order: 0 = stall, 1 = bubble, 2 = flush.
    logic [CNT_W-1:0] cnt_q [3];
    logic [CNT_W-1:0] cnt_d [3];

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
            always_comb begin
                cnt_d[gi] = cnt_q[gi];
                if (counter_clr)
                    cnt_d[gi] = '0;
                else if (cnt_inc[gi] && (cnt_q[gi] != {CNT_W{1'b1}}))
                    cnt_d[gi] = cnt_q[gi] + CNT_W'(1);
            end

            always_ff @(posedge clk) begin
                if (!rst)
                    cnt_q[gi] <= '0;
                else
                    cnt_q[gi] <= cnt_d[gi];
            end
        end
    endgenerate

    assign stall_cnt  = cnt_q[0];
    assign bubble_cnt = cnt_q[1];
    assign flush_cnt  = cnt_q[2];

endmodule
